// File: rtl/kernel_shiftreg.sv
// kernel_shiftreg
//   Stride-1 sliding-window shift register for a pixel stream. It collects the
//   last BLOCK_WIDTH accepted samples into one flat word. The oldest sample is
//   in the MSB slice and the newest is in bits [DATA_WIDTH-1:0].
//   Valid/ready handshake on both sides, with full backpressure propagation.
//
// Parameters
//   DATA_WIDTH   : bits per input sample
//   BLOCK_WIDTH  : samples per window (>= 1)
//   OUTPUT_WIDTH : derived, DATA_WIDTH*BLOCK_WIDTH (not overridable)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   in_data    : input sample
//   in_valid   : in_data is valid
//   in_ready   : block can accept a sample this cycle
//   out_data   : current window, driven directly from the window register
//   out_valid  : out_data holds a complete, not-yet-consumed window
//   out_ready  : downstream accepts the window
//   clear      : (only with KERNEL_SHIFTREG_CLEAR_EN) synchronous line/frame
//                clear; restarts the fill and drops any pending window
//
// Build option
//   KERNEL_SHIFTREG_CLEAR_EN : adds the clear input port.
module kernel_shiftreg #(
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned BLOCK_WIDTH  = 3,
  localparam int unsigned OUTPUT_WIDTH = DATA_WIDTH * BLOCK_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef KERNEL_SHIFTREG_CLEAR_EN
  input  logic                    clear,
`endif
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned CW = $clog2(BLOCK_WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BLOCK_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_WIDTH - 1);

  logic [OUTPUT_WIDTH-1:0] window;
  logic [OUTPUT_WIDTH-1:0] window_shifted;
  logic [CW-1:0]           fill_cnt;
  logic                    valid_q;
  logic                    clear_i;
  logic                    accept;

`ifdef KERNEL_SHIFTREG_CLEAR_EN
  assign clear_i = clear;
`else
  assign clear_i = 1'b0;
`endif

  // A pending window blocks new input unless it is consumed in the same cycle.
  // A clear also blocks input for that cycle.
  assign in_ready  = !clear_i && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_data  = window;
  assign out_valid = valid_q;

  // A single-sample window has no older slice to keep. That case is split
  // out so that the slice bounds are never negative.
  generate
    if (BLOCK_WIDTH == 1) begin : g_single
      assign window_shifted = in_data;
    end else begin : g_multi
      assign window_shifted = {window[OUTPUT_WIDTH-DATA_WIDTH-1:0], in_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      window   <= '0;
      fill_cnt <= '0;
      valid_q  <= 1'b0;
    end else if (clear_i) begin
      // The window contents are kept. They are overwritten before the next
      // output because the fill count restarts from zero.
      fill_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        window <= window_shifted;
        if (fill_cnt != FULL_CNT) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
      if (accept && (fill_cnt >= LAST_CNT)) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_shiftreg.sv
// Testbench for kernel_shiftreg. It uses directed vectors and hand-computed
// expected windows. A second instance with BLOCK_WIDTH = 1 covers the
// single-sample boundary case.
module tb_kernel_shiftreg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  out_data1;
  logic        out_valid1;
  logic        out_ready1;

`ifdef KERNEL_SHIFTREG_CLEAR_EN
  logic        clear;
  logic        clear1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_shiftreg #(.DATA_WIDTH(8), .BLOCK_WIDTH(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef KERNEL_SHIFTREG_CLEAR_EN
    .clear     (clear),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  kernel_shiftreg #(.DATA_WIDTH(8), .BLOCK_WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
`ifdef KERNEL_SHIFTREG_CLEAR_EN
    .clear     (clear1),
`endif
    .in_data   (in_data1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_data  (out_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1)
  );

  // Advance one rising edge, then settle #1 past it so that registered
  // outputs and combinational in_ready can be sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
`ifdef KERNEL_SHIFTREG_CLEAR_EN
    clear = 1'b0; clear1 = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 24'h000000) begin
      errors++; $display("FAIL reset_data: got %h expected 000000", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b1;
    send(8'h11);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fill_1_valid: got %b expected 0", out_valid);
    end
    send(8'h22);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fill_2_valid: got %b expected 0", out_valid);
    end
    send(8'h33);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h112233) begin
      errors++;
      $display("FAIL fill_3_window: got valid=%b data=%h expected valid=1 data=112233",
               out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  samples [2] = '{8'h44, 8'h55};
    logic [23:0] expect_w [2] = '{24'h223344, 24'h334455};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = samples[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready_%0d: got %b expected 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== expect_w[i]) begin
        errors++;
        $display("FAIL stream_window_%0d: got valid=%b data=%h expected valid=1 data=%h",
                 i, out_valid, out_data, expect_w[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gap();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 24'h334455) begin
        errors++;
        $display("FAIL gap_hold_%0d: got valid=%b data=%h expected valid=0 data=334455",
                 i, out_valid, out_data);
      end
    end
    send(8'h66);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h445566) begin
      errors++;
      $display("FAIL gap_resume: got valid=%b data=%h expected valid=1 data=445566",
               out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_initial: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 24'h445566 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h in_ready=%b expected valid=1 data=445566 in_ready=0",
                 i, out_valid, out_data, in_ready);
      end
    end
    // Consume the held window and accept a new sample on the same edge.
    out_ready = 1'b1;
    in_data   = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h556677) begin
      errors++;
      $display("FAIL bp_release_window: got valid=%b data=%h expected valid=1 data=556677",
               out_valid, out_data);
    end
    send(8'h88);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h667788) begin
      errors++;
      $display("FAIL bp_next_window: got valid=%b data=%h expected valid=1 data=667788",
               out_valid, out_data);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 24'h000000) begin
      errors++;
      $display("FAIL midrst_state: got valid=%b data=%h expected valid=0 data=000000",
               out_valid, out_data);
    end
    send(8'h01);
    send(8'h02);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_refill: got %b expected 0", out_valid);
    end
    send(8'h03);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h010203) begin
      errors++;
      $display("FAIL midrst_window: got valid=%b data=%h expected valid=1 data=010203",
               out_valid, out_data);
    end
  endtask

  task automatic test_block_width_one();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 8'hAB;
    tick();
    checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'hAB) begin
      errors++;
      $display("FAIL bw1_first: got valid=%b data=%h expected valid=1 data=ab",
               out_valid1, out_data1);
    end
    in_data1 = 8'hCD;
    tick();
    checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'hCD) begin
      errors++;
      $display("FAIL bw1_second: got valid=%b data=%h expected valid=1 data=cd",
               out_valid1, out_data1);
    end
    in_valid1 = 1'b0;
    tick();
    checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 8'hCD) begin
      errors++;
      $display("FAIL bw1_idle: got valid=%b data=%h expected valid=0 data=cd",
               out_valid1, out_data1);
    end
  endtask

`ifdef KERNEL_SHIFTREG_CLEAR_EN
  task automatic test_clear();
    out_ready = 1'b1;
    send(8'h04);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'h020304) begin
      errors++;
      $display("FAIL clr_pre_window: got valid=%b data=%h expected valid=1 data=020304",
               out_valid, out_data);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_in_ready: got %b expected 0", in_ready);
    end
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_valid: got %b expected 0", out_valid);
    end
    send(8'hA1);
    send(8'hA2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_refill: got %b expected 0", out_valid);
    end
    send(8'hA3);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hA1A2A3) begin
      errors++;
      $display("FAIL clr_window: got valid=%b data=%h expected valid=1 data=a1a2a3",
               out_valid, out_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_mid_reset();
    test_block_width_one();
`ifdef KERNEL_SHIFTREG_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
